rf_wport_sched: RTL and testbench
=================================

// Module: rf_wport_sched
// PURPOSE
//  Scheduler for the single register-file write port. It shares the port between the WB stage
//  write bus and a long-latency divider result stream, and keeps a scoreboard of registers with
//  pending divider writes so ID can stall on them. It sits between wb_stage, the divider and the regfile.
//  WB always has priority. The divider result is parked in a 1-entry buffer and drained on free slots.
//  A starvation counter forces a WB bubble when the buffer waits too long.
// PARAMETERS
//  STARVE_LIMIT  4    cycles a valid buffer may wait behind WB writes before MEM->WB is blocked
//  CNT_W         3    width of starvation counter; must satisfy 2**CNT_W > STARVE_LIMIT
// PORTS
//  clk            in   1   clock
//  reset          in   1   synchronous, active-high reset
//  ws_rf_bus      in   38  {we, waddr[4:0], wdata[31:0]} from WB stage; we already qualified by ws_valid
//  div_wb_valid   in   1   divider result valid
//  div_wb_ready   out  1   buffer can accept divider result this cycle
//  div_wb_dest    in   5   divider destination register
//  div_wb_data    in   32  divider result
//  ds_div_issue   in   1   ID issues a divide this cycle (one pulse per instruction)
//  ds_div_dest    in   5   destination of issued divide
//  ds_rs1         in   5   ID source 1
//  ds_rs2         in   5   ID source 2
//  ds_dest        in   5   ID destination; WAW check
//  ds_sb_stall    out  1   ID must stall: rs1/rs2/dest hits a pending register
//  ms_wb_block    out  1   forces ws_allow_in low upstream for one cycle (starvation relief)
//  sb_fwd_bus     out  38  {buf_valid, buf_dest, buf_data} forwarding of parked divider result
//  rf_we          out  1   regfile write enable
//  rf_waddr       out  5   regfile write address
//  rf_wdata       out  32  regfile write data
// BEHAVIOUR
//  Reset: buf_valid=0, pending mask=0, starve_cnt=0, ms_wb_block=0.
//   Outputs then: rf_we=0, div_wb_ready=1, ds_sb_stall=0, sb_fwd_bus=0.
//  Write port (combinational, 0-cycle latency):
//   - If ws_we=1: rf_* = WB bus.
//   - Else if buf_valid: rf_* = buffer and the buffer drains.
//   - Else: rf_we=0.
//   - rf_we is never asserted with waddr=0; buffer entries with dest 0 drain silently.
//  Buffer handshake:
//   - div_wb_ready = !buf_valid || drain. A full buffer that drains accepts new data the same cycle.
//   - Transfer occurs when div_wb_valid && div_wb_ready. Data is captured at the clock edge and
//     visible on sb_fwd_bus the next cycle.
//  Starvation:
//   - starve_cnt increments each cycle with buf_valid && ws_we, and clears on drain or when !buf_valid.
//   - When starve_cnt==STARVE_LIMIT-1 and still blocked, ms_wb_block=1 is registered for exactly
//     one cycle. The next-cycle WB slot is then empty and the buffer drains.
//   - ms_wb_block is never asserted two consecutive cycles.
//  Scoreboard (32-bit pending mask):
//   - Set bit ds_div_dest on ds_div_issue (ignored when dest==0).
//   - Clear bit buf_dest on drain.
//   - Set and clear of the same index in the same cycle: set wins.
//   - ds_sb_stall = pending[rs1]|pending[rs2]|pending[ds_dest], with index 0 always reading 0.
//   - A register whose result sits in the buffer stays pending until drained. sb_fwd_bus is
//     informational for forwarding; stall still holds.
//  Reset mid-operation clears the buffer and mask; the in-flight divider result is dropped,
//   and the divider is reset by the same reset.
// STRUCTURE
//  Shared pkg/defines: RF_BUS_W=38, RF_ADDR_W=5, RF_DATA_W=32, bus field offsets (WE=37, ADDR=36:32).
//  One sub-module: rf_pending_sb (32-bit mask, set/clear/3 read ports).
//  Buffer, starvation counter and port mux stay in the top level.
// TESTING
//  1 Idle WB, div result dest=5 data=0x1234 -> rf_we=1 waddr=5 wdata=0x1234 the cycle after accept;
//    pending[5] clears.
//  2 WB writes r3 every cycle, buffer holds r7 -> ms_wb_block=1 after 4 blocked cycles.
//    Next cycle rf_waddr=7, then WB resumes.
//  3 ds_div_issue dest=9, then ds_rs2=9 -> ds_sb_stall=1 until the r9 drain cycle; 0 the cycle after.
//  4 Buffer full and draining while a new div result is valid -> div_wb_ready=1,
//    new result captured with no bubble.
//  5 Issue dest=4 in the same cycle the buffer drains r4 -> pending[4] remains 1.
//  6 Assert reset with buffer valid and pending bits set -> all cleared next cycle;
//    rf_we=0 and div_wb_ready=1.

Source files
------------

// File: rtl/rf_wport_sched_pkg.sv
// Shared widths, write-bus layout and port-source encoding for the
// register-file write-port scheduler.
package rf_wport_sched_pkg;

    localparam int RF_BUS_W       = 38;
    localparam int RF_ADDR_W      = 5;
    localparam int RF_DATA_W      = 32;
    localparam int RF_BUS_WE      = 37;
    localparam int RF_BUS_ADDR_HI = 36;
    localparam int RF_BUS_ADDR_LO = 32;

    // Field order matches the {we, waddr, wdata} WB bus so a cast unpacks it.
    typedef struct packed {
        logic                 we;
        logic [RF_ADDR_W-1:0] addr;
        logic [RF_DATA_W-1:0] data;
    } rf_wr_t;

    typedef enum logic [1:0] {
        PORT_IDLE,
        PORT_WB,
        PORT_BUF
    } port_src_e;

endpackage

// File: rtl/rf_wport_sched_if.sv
// Divider result stream: valid/ready handshake carrying the destination
// register and the result data.
interface rf_wport_sched_if;
    import rf_wport_sched_pkg::*;

    logic                 div_wb_valid;
    logic                 div_wb_ready;
    logic [RF_ADDR_W-1:0] div_wb_dest;
    logic [RF_DATA_W-1:0] div_wb_data;

    modport master (
        output div_wb_valid,
        output div_wb_dest,
        output div_wb_data,
        input  div_wb_ready
    );

    modport slave (
        input  div_wb_valid,
        input  div_wb_dest,
        input  div_wb_data,
        output div_wb_ready
    );
endinterface

// File: rtl/rf_wport_sched_pending_sb.sv
// Pending-write scoreboard: one bit per architectural register, set on divide
// issue and cleared when the divider result reaches the register file.
module rf_pending_sb
    import rf_wport_sched_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 set_i,
    input  logic [RF_ADDR_W-1:0] set_idx_i,
    input  logic                 clr_i,
    input  logic [RF_ADDR_W-1:0] clr_idx_i,
    input  logic [RF_ADDR_W-1:0] rd0_idx_i,
    input  logic [RF_ADDR_W-1:0] rd1_idx_i,
    input  logic [RF_ADDR_W-1:0] rd2_idx_i,
    output logic                 rd0_hit_o,
    output logic                 rd1_hit_o,
    output logic                 rd2_hit_o
);

    logic [31:0] pending_q;
    logic [31:0] pending_d;

    // Set is applied after clear so a same-index set/clear leaves the bit set;
    // r0 is never tracked.
    always_comb begin
        pending_d = pending_q;
        if (clr_i) begin
            pending_d[clr_idx_i] = 1'b0;
        end
        if (set_i) begin
            pending_d[set_idx_i] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign rd0_hit_o = pending_q[rd0_idx_i];
    assign rd1_hit_o = pending_q[rd1_idx_i];
    assign rd2_hit_o = pending_q[rd2_idx_i];

endmodule

// File: rtl/rf_wport_sched.sv
// Arbitrates the single regfile write port between the WB stage and a parked
// divider result, with starvation relief and a pending-register scoreboard.
module rf_wport_sched
    import rf_wport_sched_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [RF_BUS_W-1:0]  ws_rf_bus,
    rf_wport_sched_if.slave      div_if,
    input  logic                 ds_div_issue,
    input  logic [RF_ADDR_W-1:0] ds_div_dest,
    input  logic [RF_ADDR_W-1:0] ds_rs1,
    input  logic [RF_ADDR_W-1:0] ds_rs2,
    input  logic [RF_ADDR_W-1:0] ds_dest,
    output logic                 ds_sb_stall,
    output logic                 ms_wb_block,
    output logic [RF_BUS_W-1:0]  sb_fwd_bus,
    output logic                 rf_we,
    output logic [RF_ADDR_W-1:0] rf_waddr,
    output logic [RF_DATA_W-1:0] rf_wdata
);

    rf_wr_t               ws;
    port_src_e            portSrc;
    logic                 drain;
    logic                 accept;
    logic                 blocked;

    logic                 buf_valid_q, buf_valid_d;
    logic [RF_ADDR_W-1:0] buf_dest_q,  buf_dest_d;
    logic [RF_DATA_W-1:0] buf_data_q,  buf_data_d;
    logic [CNT_W-1:0]     starve_cnt_q, starve_cnt_d;
    logic                 wb_block_q,  wb_block_d;

    logic                 hitRs1, hitRs2, hitDest;

    assign ws = rf_wr_t'(ws_rf_bus);

    // WB owns the port whenever it writes; the buffer only gets idle slots.
    always_comb begin
        portSrc  = PORT_IDLE;
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        if (ws.we) begin
            portSrc = PORT_WB;
        end else if (buf_valid_q) begin
            portSrc = PORT_BUF;
        end
        case (portSrc)
            PORT_WB: begin
                rf_we    = (ws.addr != '0);
                rf_waddr = ws.addr;
                rf_wdata = ws.data;
            end
            PORT_BUF: begin
                rf_we    = (buf_dest_q != '0);
                rf_waddr = buf_dest_q;
                rf_wdata = buf_data_q;
            end
            default: ;
        endcase
    end

    assign drain   = (portSrc == PORT_BUF);
    assign blocked = buf_valid_q && ws.we;
    assign div_if.div_wb_ready = !buf_valid_q || drain;
    assign accept  = div_if.div_wb_valid && div_if.div_wb_ready;

    // The counter restarts when it fires so a WB stage that ignores the bubble
    // is still relieved periodically.
    always_comb begin
        buf_valid_d  = buf_valid_q;
        buf_dest_d   = buf_dest_q;
        buf_data_d   = buf_data_q;
        starve_cnt_d = '0;
        wb_block_d   = 1'b0;
        if (accept) begin
            buf_valid_d = 1'b1;
            buf_dest_d  = div_if.div_wb_dest;
            buf_data_d  = div_if.div_wb_data;
        end else if (drain) begin
            buf_valid_d = 1'b0;
        end
        if (blocked) begin
            if (starve_cnt_q == CNT_W'(STARVE_LIMIT - 1)) begin
                wb_block_d = !wb_block_q;
            end else begin
                starve_cnt_d = starve_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            buf_valid_q  <= 1'b0;
            buf_dest_q   <= '0;
            buf_data_q   <= '0;
            starve_cnt_q <= '0;
            wb_block_q   <= 1'b0;
        end else begin
            buf_valid_q  <= buf_valid_d;
            buf_dest_q   <= buf_dest_d;
            buf_data_q   <= buf_data_d;
            starve_cnt_q <= starve_cnt_d;
            wb_block_q   <= wb_block_d;
        end
    end

    assign ms_wb_block = wb_block_q;
    assign sb_fwd_bus  = buf_valid_q ? {1'b1, buf_dest_q, buf_data_q} : '0;

    rf_pending_sb u_pending_sb (
        .clk       (clk),
        .reset     (reset),
        .set_i     (ds_div_issue),
        .set_idx_i (ds_div_dest),
        .clr_i     (drain),
        .clr_idx_i (buf_dest_q),
        .rd0_idx_i (ds_rs1),
        .rd1_idx_i (ds_rs2),
        .rd2_idx_i (ds_dest),
        .rd0_hit_o (hitRs1),
        .rd1_hit_o (hitRs2),
        .rd2_hit_o (hitDest)
    );

    assign ds_sb_stall = hitRs1 || hitRs2 || hitDest;

endmodule

// File: tb/tb_rf_wport_sched.sv
// Directed bench for rf_wport_sched: drives WB, divider and ID traffic step by
// step and checks the write port, handshake, starvation relief and scoreboard.
module tb_rf_wport_sched;
    import rf_wport_sched_pkg::*;

    logic                 clk;
    logic                 reset;
    logic [RF_BUS_W-1:0]  wsRfBus;
    logic                 dsDivIssue;
    logic [RF_ADDR_W-1:0] dsDivDest;
    logic [RF_ADDR_W-1:0] dsRs1;
    logic [RF_ADDR_W-1:0] dsRs2;
    logic [RF_ADDR_W-1:0] dsDest;
    logic                 dsSbStall;
    logic                 msWbBlock;
    logic [RF_BUS_W-1:0]  sbFwdBus;
    logic                 rfWe;
    logic [RF_ADDR_W-1:0] rfWaddr;
    logic [RF_DATA_W-1:0] rfWdata;

    int checkCount = 0;
    int failCount  = 0;

    rf_wport_sched_if divBus ();

    rf_wport_sched #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .ws_rf_bus    (wsRfBus),
        .div_if       (divBus.slave),
        .ds_div_issue (dsDivIssue),
        .ds_div_dest  (dsDivDest),
        .ds_rs1       (dsRs1),
        .ds_rs2       (dsRs2),
        .ds_dest      (dsDest),
        .ds_sb_stall  (dsSbStall),
        .ms_wb_block  (msWbBlock),
        .sb_fwd_bus   (sbFwdBus),
        .rf_we        (rfWe),
        .rf_waddr     (rfWaddr),
        .rf_wdata     (rfWdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [RF_BUS_W-1:0] wbBus(input logic we, input logic [4:0] addr,
                                                   input logic [31:0] data);
        return {we, addr, data};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [RF_BUS_W-1:0] ws, input logic divValid,
                                 input logic [4:0] divDest, input logic [31:0] divData,
                                 input logic issue, input logic [4:0] issueDest);
        wsRfBus             = ws;
        divBus.div_wb_valid = divValid;
        divBus.div_wb_dest  = divDest;
        divBus.div_wb_data  = divData;
        dsDivIssue          = issue;
        dsDivDest           = issueDest;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        reset = 1'b1;
        dsRs1 = '0; dsRs2 = '0; dsDest = '0;
        applyStimulus('0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        tick(); tick();
        reset = 1'b0;
        #1;
        checkOutput("reset_rf_we", rfWe, 0);
        checkOutput("reset_ready", divBus.div_wb_ready, 1);
        checkOutput("reset_stall", dsSbStall, 0);
        checkOutput("reset_fwd", sbFwdBus, 0);
        checkOutput("reset_block", msWbBlock, 0);

        // 1: idle WB, divider result r5 drains the cycle after accept
        applyStimulus('0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5);
        tick();
        dsRs1 = 5'd5;
        applyStimulus('0, 1'b1, 5'd5, 32'h1234, 1'b0, 5'd0);
        checkOutput("t1_stall_pending", dsSbStall, 1);
        checkOutput("t1_ready_empty", divBus.div_wb_ready, 1);
        checkOutput("t1_no_write_yet", rfWe, 0);
        tick();
        applyStimulus('0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        checkOutput("t1_fwd", sbFwdBus, {1'b1, 5'd5, 32'h1234});
        checkOutput("t1_rf_we", rfWe, 1);
        checkOutput("t1_rf_waddr", rfWaddr, 5);
        checkOutput("t1_rf_wdata", rfWdata, 32'h1234);
        checkOutput("t1_stall_in_buffer", dsSbStall, 1);
        tick();
        checkOutput("t1_stall_cleared", dsSbStall, 0);
        checkOutput("t1_port_idle", rfWe, 0);
        checkOutput("t1_fwd_empty", sbFwdBus, 0);
        dsRs1 = '0;

        // 3: pending r9 seen on rs2, held one cycle by a WB write
        applyStimulus('0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9);
        tick();
        dsRs2 = 5'd9;
        applyStimulus('0, 1'b1, 5'd9, 32'hAAAA_5555, 1'b0, 5'd0);
        checkOutput("t3_stall_issue", dsSbStall, 1);
        tick();
        applyStimulus(wbBus(1'b1, 5'd3, 32'h33), 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        checkOutput("t3_wb_wins", rfWaddr, 3);
        checkOutput("t3_wb_data", rfWdata, 32'h33);
        checkOutput("t3_ready_full", divBus.div_wb_ready, 0);
        checkOutput("t3_stall_blocked", dsSbStall, 1);
        tick();
        applyStimulus('0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        checkOutput("t3_drain_addr", rfWaddr, 9);
        checkOutput("t3_drain_data", rfWdata, 32'hAAAA_5555);
        checkOutput("t3_stall_drain_cycle", dsSbStall, 1);
        tick();
        checkOutput("t3_stall_after", dsSbStall, 0);
        dsRs2 = '0;

        // 2: WB writes r3 every cycle while r7 waits in the buffer
        dsRs1 = 5'd7;
        applyStimulus(wbBus(1'b1, 5'd3, 32'h3), 1'b1, 5'd7, 32'h77, 1'b1, 5'd7);
        checkOutput("t2_ready_load", divBus.div_wb_ready, 1);
        tick();
        applyStimulus(wbBus(1'b1, 5'd3, 32'h3), 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        for (int i = 0; i < 4; i++) begin
            checkOutput("t2_block_wait", msWbBlock, 0);
            checkOutput("t2_wb_addr", rfWaddr, 3);
            checkOutput("t2_stall_wait", dsSbStall, 1);
            tick();
        end
        checkOutput("t2_block_set", msWbBlock, 1);
        applyStimulus('0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        checkOutput("t2_drain_we", rfWe, 1);
        checkOutput("t2_drain_addr", rfWaddr, 7);
        checkOutput("t2_drain_data", rfWdata, 32'h77);
        tick();
        applyStimulus(wbBus(1'b1, 5'd3, 32'h4), 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        checkOutput("t2_block_single", msWbBlock, 0);
        checkOutput("t2_wb_resume", rfWaddr, 3);
        checkOutput("t2_fwd_empty", sbFwdBus, 0);
        checkOutput("t2_stall_cleared", dsSbStall, 0);
        tick();
        checkOutput("t2_block_stays_low", msWbBlock, 0);
        dsRs1 = '0;

        // 4: full buffer draining accepts a new result with no bubble
        applyStimulus('0, 1'b1, 5'd10, 32'hA0, 1'b0, 5'd0);
        tick();
        applyStimulus('0, 1'b1, 5'd11, 32'hB0, 1'b0, 5'd0);
        checkOutput("t4_ready_drain", divBus.div_wb_ready, 1);
        checkOutput("t4_drain_addr", rfWaddr, 10);
        tick();
        applyStimulus('0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        checkOutput("t4_fwd_new", sbFwdBus, {1'b1, 5'd11, 32'hB0});
        checkOutput("t4_drain_new", rfWaddr, 11);
        checkOutput("t4_drain_new_data", rfWdata, 32'hB0);
        tick();

        // dest r0 and WB to r0 never assert the write enable
        applyStimulus('0, 1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0);
        tick();
        applyStimulus('0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        checkOutput("r0_buf_silent", rfWe, 0);
        checkOutput("r0_buf_drains", divBus.div_wb_ready, 1);
        tick();
        checkOutput("r0_buf_gone", sbFwdBus, 0);
        applyStimulus(wbBus(1'b1, 5'd0, 32'h1), 1'b0, 5'd0, 32'h0, 1'b1, 5'd0);
        checkOutput("r0_wb_silent", rfWe, 0);
        tick();
        applyStimulus('0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        checkOutput("r0_never_pending", dsSbStall, 0);

        // 5: re-issue of r4 in the cycle its older result drains
        applyStimulus('0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4);
        tick();
        applyStimulus('0, 1'b1, 5'd4, 32'h44, 1'b0, 5'd0);
        tick();
        applyStimulus('0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4);
        checkOutput("t5_drain_addr", rfWaddr, 4);
        tick();
        applyStimulus('0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        dsDest = 5'd4;
        #1;
        checkOutput("t5_set_wins", dsSbStall, 1);
        dsDest = '0;

        // 6: reset with buffer valid and pending bits set
        applyStimulus(wbBus(1'b1, 5'd3, 32'h5), 1'b1, 5'd12, 32'hC0, 1'b1, 5'd12);
        tick();
        applyStimulus(wbBus(1'b1, 5'd3, 32'h6), 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        checkOutput("t6_buf_held", sbFwdBus, {1'b1, 5'd12, 32'hC0});
        reset = 1'b1;
        tick();
        reset = 1'b0;
        dsRs1 = 5'd12;
        dsRs2 = 5'd4;
        applyStimulus('0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        checkOutput("t6_stall_cleared", dsSbStall, 0);
        checkOutput("t6_rf_we", rfWe, 0);
        checkOutput("t6_ready", divBus.div_wb_ready, 1);
        checkOutput("t6_fwd", sbFwdBus, 0);
        checkOutput("t6_block", msWbBlock, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
